// File: rtl/axi4_lite_cmd_queue_pkg.sv
// Shared widths, command record and FSM encoding for the AXI4-Lite command queue.
package axi4_lite_cmd_queue_pkg;

    localparam int Addr_Width = 32;
    localparam int Data_Width = 32;

    typedef struct packed {
        logic                  write;
        logic [Addr_Width-1:0] addr;
        logic [Data_Width-1:0] data;
    } axi4_cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } cmdq_state_t;

endpackage

// File: rtl/axi4_lite_cmd_queue_if.sv
// Producer command/response handshakes plus the start/done signals toward axi4_lite_master.
interface axi4_lite_cmd_queue_if
    import axi4_lite_cmd_queue_pkg::*;
#(
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [Addr_Width-1:0] cmd_addr;
    logic [Data_Width-1:0] cmd_wdata;

    logic                  rd_en;
    logic                  wr_en;
    logic [Addr_Width-1:0] Read_Address;
    logic [Addr_Width-1:0] Write_Address;
    logic [Data_Width-1:0] Write_Data;
    logic                  rd_done;
    logic                  wr_done;
    logic [Data_Width-1:0] rd_data;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic                  rsp_write;
    logic [Data_Width-1:0] rsp_data;
    logic                  rsp_err;
    logic [CNT_W-1:0]      count;

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  rd_done, wr_done, rd_data, rsp_ready,
        output cmd_ready, rd_en, wr_en, Read_Address, Write_Address, Write_Data,
        output rsp_valid, rsp_write, rsp_data, rsp_err, count
    );

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output rd_done, wr_done, rd_data, rsp_ready,
        input  cmd_ready, rd_en, wr_en, Read_Address, Write_Address, Write_Data,
        input  rsp_valid, rsp_write, rsp_data, rsp_err, count
    );

endinterface

// File: rtl/axi4_lite_cmd_queue_fifo.sv
// Purpose: DEPTH-entry command FIFO; head is combinationally visible whenever not empty.
// Latency: a push is visible at the head the cycle after the write edge.
// Backpressure: push ignored when full, pop ignored when empty; no bypass.
module axi4_cmd_fifo
    import axi4_lite_cmd_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  axi4_cmd_t                    push_dat,
    input  logic                         pop,
    output axi4_cmd_t                    head,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    axi4_cmd_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap without compare logic.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_push && !do_pop)      count <= count + CNT_W'(1);
            else if (do_pop && !do_push) count <= count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/axi4_lite_cmd_queue.sv
// Purpose: queues producer commands and issues them one at a time to axi4_lite_master; CMDQ_TIMEOUT_EN adds a WAIT watchdog.
// Latency: push at edge N -> rd_en/wr_en sampled high at edge N+2; done at edge M -> rsp_valid sampled high at edge M+1.
// Backpressure: cmd_ready = !full; the response is held until rsp_ready, and nothing new issues meanwhile.
module axi4_lite_cmd_queue
    import axi4_lite_cmd_queue_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input logic                   ACLK,
    input logic                   ARESET,
    axi4_lite_cmd_queue_if.slave  q
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("axi4_lite_cmd_queue: DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES >= 1");
    end

    cmdq_state_t           state;
    cmdq_state_t           state_nxt;
    axi4_cmd_t             head;
    axi4_cmd_t             push_dat;
    logic                  full;
    logic                  empty;
    logic                  pop;
    logic [CNT_W-1:0]      fifo_count;
    logic                  cur_write;
    logic                  done_match;
    logic                  timed_out;
    logic [Addr_Width-1:0] rd_addr;
    logic [Addr_Width-1:0] wr_addr;
    logic [Data_Width-1:0] wr_data;
    logic [Data_Width-1:0] rsp_data;

    assign push_dat = '{write: q.cmd_write, addr: q.cmd_addr, data: q.cmd_wdata};

    axi4_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (ACLK),
        .rst      (ARESET),
        .push     (q.cmd_valid),
        .push_dat (push_dat),
        .pop      (pop),
        .head     (head),
        .full     (full),
        .empty    (empty),
        .count    (fifo_count)
    );

    assign done_match = cur_write ? q.wr_done : q.rd_done;

    always_ff @(posedge ACLK) begin
        if (ARESET) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!empty) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (done_match || timed_out) state_nxt = RESP;
            RESP:    if (q.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pop         = 1'b0;
        q.rd_en     = 1'b0;
        q.wr_en     = 1'b0;
        q.rsp_valid = 1'b0;
        case (state)
            ISSUE: begin
                pop     = 1'b1;
                q.rd_en = !cur_write;
                q.wr_en = cur_write;
            end
            RESP:    q.rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Address/data are latched on the IDLE->ISSUE edge so they are already stable while the start pulse is high.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            cur_write <= 1'b0;
            rd_addr   <= '0;
            wr_addr   <= '0;
            wr_data   <= '0;
            rsp_data  <= '0;
        end else begin
            if (state == IDLE && !empty) begin
                cur_write <= head.write;
                if (head.write) begin
                    wr_addr <= head.addr;
                    wr_data <= head.data;
                end else begin
                    rd_addr <= head.addr;
                end
            end
            if (state == WAIT && (done_match || timed_out))
                rsp_data <= (done_match && !cur_write) ? q.rd_data : '0;
        end
    end

`ifdef CMDQ_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] wait_cnt;
    logic             rsp_err_q;

    // The compare fires on the edge that would take the count to TIMEOUT_CYCLES.
    assign timed_out = (wait_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wait_cnt  <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            if (state == ISSUE)     wait_cnt <= '0;
            else if (state == WAIT) wait_cnt <= wait_cnt + TMO_W'(1);
            if (state == WAIT && timed_out && !done_match) rsp_err_q <= 1'b1;
            else if (state == RESP && q.rsp_ready)         rsp_err_q <= 1'b0;
        end
    end

    assign q.rsp_err = rsp_err_q;
`else
    assign timed_out = 1'b0;
    assign q.rsp_err = 1'b0;
`endif

    assign q.cmd_ready     = !full;
    assign q.count         = fifo_count;
    assign q.Read_Address  = rd_addr;
    assign q.Write_Address = wr_addr;
    assign q.Write_Data    = wr_data;
    assign q.rsp_write     = cur_write;
    assign q.rsp_data      = rsp_data;

endmodule

// File: tb/tb_axi4_lite_cmd_queue.sv
// Bench for axi4_lite_cmd_queue: directed scenarios plus a randomized run against an in-order memory model.
module tb_axi4_lite_cmd_queue;
    import axi4_lite_cmd_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int TMO   = 16;
    localparam int NRAND = 40;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    axi4_lite_cmd_queue_if #(.DEPTH(DEPTH)) bus ();

    axi4_lite_cmd_queue #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .ACLK   (clk),
        .ARESET (rst),
        .q      (bus)
    );

    typedef struct {
        bit          w;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] r;
    } tcmd_t;

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.rd_done   = 1'b0;
        bus.wr_done   = 1'b0;
        bus.rd_data   = '0;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic push(input bit w, input logic [31:0] a, input logic [31:0] d);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        step();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_pulse(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.rd_en || bus.wr_en) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        step();
        step();
        total++; if (bus.count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", bus.count); end
        total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%b want=1", bus.cmd_ready); end
        total++; if ({bus.rd_en, bus.wr_en, bus.rsp_valid, bus.rsp_err} !== 4'b0) begin
            bad++; $display("FAIL reset_flags got rd_en/wr_en/rsp_valid/rsp_err=%b want=0000", {bus.rd_en, bus.wr_en, bus.rsp_valid, bus.rsp_err});
        end
        total++; if ({bus.Read_Address, bus.Write_Address, bus.Write_Data, bus.rsp_data} !== 128'd0) begin
            bad++; $display("FAIL reset_data got ra=%h wa=%h wd=%h rd=%h want=0", bus.Read_Address, bus.Write_Address, bus.Write_Data, bus.rsp_data);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_write_read();
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 32'h10; bus.cmd_wdata = 32'hDEAD_BEEF;
        step();
        total++; if (bus.wr_en !== 1'b0) begin bad++; $display("FAIL wr_early got=%b want=0", bus.wr_en); end
        bus.cmd_write = 1'b0; bus.cmd_wdata = '0;
        step();
        bus.cmd_valid = 1'b0;
        total++; if (bus.wr_en !== 1'b1 || bus.rd_en !== 1'b0 || bus.Write_Address !== 32'h10 || bus.Write_Data !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL wr_issue got wr_en=%b rd_en=%b wa=%h wd=%h want 1 0 10 deadbeef", bus.wr_en, bus.rd_en, bus.Write_Address, bus.Write_Data);
        end
        step();
        total++; if (bus.wr_en !== 1'b0) begin bad++; $display("FAIL wr_pulse_width got=%b want=0", bus.wr_en); end
        bus.wr_done = 1'b1; step(); bus.wr_done = 1'b0;
        total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_write !== 1'b1 || bus.rsp_data !== 32'd0) begin
            bad++; $display("FAIL wr_rsp got v=%b w=%b d=%h want 1 1 0", bus.rsp_valid, bus.rsp_write, bus.rsp_data);
        end
        bus.rsp_ready = 1'b1; step(); bus.rsp_ready = 1'b0;
        total++; if (bus.rd_en !== 1'b0) begin bad++; $display("FAIL rd_too_soon got=%b want=0", bus.rd_en); end
        step();
        total++; if (bus.rd_en !== 1'b1 || bus.Read_Address !== 32'h10) begin
            bad++; $display("FAIL rd_issue got rd_en=%b ra=%h want 1 10", bus.rd_en, bus.Read_Address);
        end
        step();
        bus.rd_done = 1'b1; bus.rd_data = 32'hDEAD_BEEF; step(); bus.rd_done = 1'b0; bus.rd_data = '0;
        total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_write !== 1'b0 || bus.rsp_data !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL rd_rsp got v=%b w=%b d=%h want 1 0 deadbeef", bus.rsp_valid, bus.rsp_write, bus.rsp_data);
        end
        bus.rsp_ready = 1'b1; step(); bus.rsp_ready = 1'b0;
        total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL rd_rsp_drop got=%b want=0", bus.rsp_valid); end
    endtask

    task automatic test_fill();
        logic [31:0] fa [5];
        logic [31:0] fd [5];
        bit          first_seen = 1'b0;
        logic [31:0] first_addr = '0;
        bit          ok;
        for (int i = 0; i < 5; i++) begin
            fa[i] = 32'h100 + 32'(i) * 4;
            fd[i] = $urandom;
        end
        for (int i = 0; i < 5; i++) begin
            total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL fill_ready_%0d got=%b want=1", i, bus.cmd_ready); end
            push(1'b1, fa[i], fd[i]);
            if (bus.wr_en) begin first_seen = 1'b1; first_addr = bus.Write_Address; end
        end
        total++; if (bus.count !== 3'd4 || bus.cmd_ready !== 1'b0) begin
            bad++; $display("FAIL fill_full got count=%0d ready=%b want 4 0", bus.count, bus.cmd_ready);
        end
        total++; if (!first_seen || first_addr !== fa[0]) begin
            bad++; $display("FAIL fill_first_issue got seen=%b addr=%h want 1 %h", first_seen, first_addr, fa[0]);
        end
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin
                wait_pulse(ok);
                total++; if (!ok || bus.wr_en !== 1'b1 || bus.Write_Address !== fa[k] || bus.Write_Data !== fd[k]) begin
                    bad++; $display("FAIL fill_issue_%0d got ok=%b wr_en=%b wa=%h wd=%h want wa=%h wd=%h", k, ok, bus.wr_en, bus.Write_Address, bus.Write_Data, fa[k], fd[k]);
                end
                step();
                if (k == 1) begin
                    total++; if (bus.count !== 3'd3 || bus.cmd_ready !== 1'b1) begin
                        bad++; $display("FAIL fill_resume got count=%0d ready=%b want 3 1", bus.count, bus.cmd_ready);
                    end
                end
            end
            bus.wr_done = 1'b1; step(); bus.wr_done = 1'b0;
            total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_write !== 1'b1) begin
                bad++; $display("FAIL fill_rsp_%0d got v=%b w=%b want 1 1", k, bus.rsp_valid, bus.rsp_write);
            end
            if (k == 0) begin
                total++; if (bus.cmd_ready !== 1'b0) begin bad++; $display("FAIL fill_still_full got=%b want=0", bus.cmd_ready); end
            end
            bus.rsp_ready = 1'b1; step(); bus.rsp_ready = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            total++; if (bus.wr_en !== 1'b0 || bus.rd_en !== 1'b0 || bus.count !== 3'd0) begin
                bad++; $display("FAIL fill_drained got wr_en=%b rd_en=%b count=%0d want 0 0 0", bus.wr_en, bus.rd_en, bus.count);
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        push(1'b0, 32'h20, 32'h0);
        push(1'b1, 32'h24, 32'h1234_5678);
        wait_pulse(ok);
        total++; if (!ok || bus.rd_en !== 1'b1 || bus.Read_Address !== 32'h20) begin
            bad++; $display("FAIL bp_rd_issue got ok=%b rd_en=%b ra=%h want 1 1 20", ok, bus.rd_en, bus.Read_Address);
        end
        step();
        bus.rd_done = 1'b1; bus.rd_data = 32'hA5A5_A5A5; step(); bus.rd_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.rd_data = $urandom;
            total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'hA5A5_A5A5 || bus.rd_en !== 1'b0 || bus.wr_en !== 1'b0) begin
                bad++; $display("FAIL bp_hold_%0d got v=%b d=%h rd_en=%b wr_en=%b want 1 a5a5a5a5 0 0", i, bus.rsp_valid, bus.rsp_data, bus.rd_en, bus.wr_en);
            end
            step();
        end
        bus.rsp_ready = 1'b1; step(); bus.rsp_ready = 1'b0;
        wait_pulse(ok);
        total++; if (!ok || bus.wr_en !== 1'b1 || bus.Write_Address !== 32'h24 || bus.Write_Data !== 32'h1234_5678) begin
            bad++; $display("FAIL bp_wr_issue got ok=%b wr_en=%b wa=%h wd=%h want 1 1 24 12345678", ok, bus.wr_en, bus.Write_Address, bus.Write_Data);
        end
        step();
        bus.wr_done = 1'b1; step(); bus.wr_done = 1'b0;
        total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_write !== 1'b1 || bus.rsp_data !== 32'd0) begin
            bad++; $display("FAIL bp_wr_rsp got v=%b w=%b d=%h want 1 1 0", bus.rsp_valid, bus.rsp_write, bus.rsp_data);
        end
        bus.rsp_ready = 1'b1; step(); bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        push(1'b0, 32'h40, 32'h0);
        push(1'b0, 32'h44, 32'h0);
        push(1'b0, 32'h48, 32'h0);
        total++; if (bus.count !== 3'd2) begin bad++; $display("FAIL rmid_pre_count got=%0d want=2", bus.count); end
        rst = 1'b1; step(); rst = 1'b0;
        total++; if (bus.count !== 3'd0 || bus.rsp_valid !== 1'b0) begin
            bad++; $display("FAIL rmid_after got count=%0d v=%b want 0 0", bus.count, bus.rsp_valid);
        end
        step();
        step();
        bus.rd_done = 1'b1; bus.rd_data = $urandom; step(); bus.rd_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++; if (bus.rsp_valid !== 1'b0 || bus.rd_en !== 1'b0 || bus.wr_en !== 1'b0 || bus.count !== 3'd0) begin
                bad++; $display("FAIL rmid_quiet_%0d got v=%b rd_en=%b wr_en=%b count=%0d want 0 0 0 0", i, bus.rsp_valid, bus.rd_en, bus.wr_en, bus.count);
            end
            step();
        end
    endtask

    task automatic test_mismatch();
        bit ok;
        push(1'b0, 32'h50, 32'h0);
        wait_pulse(ok);
        total++; if (!ok || bus.rd_en !== 1'b1) begin bad++; $display("FAIL mm_issue got ok=%b rd_en=%b want 1 1", ok, bus.rd_en); end
        step();
        bus.wr_done = 1'b1; step(); bus.wr_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL mm_ignored_%0d got v=%b want 0", i, bus.rsp_valid); end
            step();
        end
        bus.rd_done = 1'b1; bus.rd_data = 32'h1357_9BDF; step(); bus.rd_done = 1'b0; bus.rd_data = '0;
        total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_write !== 1'b0 || bus.rsp_data !== 32'h1357_9BDF) begin
            bad++; $display("FAIL mm_rsp got v=%b w=%b d=%h want 1 0 13579bdf", bus.rsp_valid, bus.rsp_write, bus.rsp_data);
        end
        bus.rsp_ready = 1'b1; step(); bus.rsp_ready = 1'b0;
    endtask

`ifdef CMDQ_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        push(1'b0, 32'h60, 32'h0);
        wait_pulse(ok);
        total++; if (!ok || bus.rd_en !== 1'b1) begin bad++; $display("FAIL tmo_issue got ok=%b rd_en=%b want 1 1", ok, bus.rd_en); end
        step();
        for (int i = 1; i <= TMO; i++) begin
            step();
            if (i < TMO) begin
                total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL tmo_early got v=%b at wait cycle %0d want 0", bus.rsp_valid, i); end
            end
        end
        total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1 || bus.rsp_data !== 32'd0) begin
            bad++; $display("FAIL tmo_rsp got v=%b err=%b d=%h want 1 1 0", bus.rsp_valid, bus.rsp_err, bus.rsp_data);
        end
        bus.rsp_ready = 1'b1; step(); bus.rsp_ready = 1'b0;
        total++; if (bus.rsp_err !== 1'b0 || bus.rsp_valid !== 1'b0) begin
            bad++; $display("FAIL tmo_clear got err=%b v=%b want 0 0", bus.rsp_err, bus.rsp_valid);
        end
    endtask
`endif

    task automatic test_random();
        tcmd_t       cmds [NRAND];
        logic [31:0] ref_mem [logic [31:0]];
        logic [31:0] bus_mem [logic [31:0]];
        int          push_i = 0, iss_i = 0, rsp_i = 0, model_cnt = 0, bus_wait = 0, cyc = 0;
        bit          busy = 1'b0, bus_w = 1'b0, outstanding = 1'b0;
        logic [31:0] bus_a = '0;

        // Expected responses follow from replaying the command list in order against a flat memory.
        for (int i = 0; i < NRAND; i++) begin
            cmds[i].w = 1'($urandom_range(0, 1));
            cmds[i].a = 32'h200 + 32'($urandom_range(0, 7)) * 4;
            cmds[i].d = $urandom;
            if (cmds[i].w) begin
                ref_mem[cmds[i].a] = cmds[i].d;
                cmds[i].r = '0;
            end else begin
                cmds[i].r = ref_mem.exists(cmds[i].a) ? ref_mem[cmds[i].a] : init_val(cmds[i].a);
            end
        end

        while (rsp_i < NRAND && cyc < 3000) begin
            bit pop_now;
            bit push_now;
            pop_now  = 1'b0;
            push_now = 1'b0;
            if (bus.rd_en || bus.wr_en) begin
                total++;
                if (iss_i >= NRAND || outstanding || (bus.rd_en && bus.wr_en)) begin
                    bad++; $display("FAIL rnd_issue_extra got idx=%0d outstanding=%b rd_en=%b wr_en=%b", iss_i, outstanding, bus.rd_en, bus.wr_en);
                end else if (bus.wr_en !== cmds[iss_i].w || (bus.wr_en ? bus.Write_Address : bus.Read_Address) !== cmds[iss_i].a
                             || (bus.wr_en && bus.Write_Data !== cmds[iss_i].d)) begin
                    bad++; $display("FAIL rnd_issue_%0d got w=%b ra=%h wa=%h wd=%h want w=%b a=%h d=%h", iss_i, bus.wr_en, bus.Read_Address,
                                    bus.Write_Address, bus.Write_Data, cmds[iss_i].w, cmds[iss_i].a, cmds[iss_i].d);
                end
                bus_w = bus.wr_en;
                bus_a = bus.wr_en ? bus.Write_Address : bus.Read_Address;
                if (bus_w) bus_mem[bus_a] = bus.Write_Data;
                busy        = 1'b1;
                bus_wait    = $urandom_range(1, 4);
                outstanding = 1'b1;
                iss_i++;
                pop_now = 1'b1;
            end
            total++; if (int'(bus.count) !== model_cnt || bus.cmd_ready !== (model_cnt < DEPTH)) begin
                bad++; $display("FAIL rnd_count got count=%0d ready=%b want %0d %b", bus.count, bus.cmd_ready, model_cnt, model_cnt < DEPTH);
            end
            if (bus.rsp_valid) begin
                total++;
                if (rsp_i >= NRAND || bus.rsp_write !== cmds[rsp_i].w || bus.rsp_data !== cmds[rsp_i].r || bus.rsp_err !== 1'b0) begin
                    bad++; $display("FAIL rnd_rsp_%0d got w=%b d=%h err=%b want w=%b d=%h err=0", rsp_i, bus.rsp_write, bus.rsp_data, bus.rsp_err,
                                    cmds[rsp_i % NRAND].w, cmds[rsp_i % NRAND].r);
                end
            end

            bus.rd_done = 1'b0;
            bus.wr_done = 1'b0;
            bus.rd_data = $urandom;
            if (busy) begin
                if (bus_wait == 0) begin
                    if (bus_w) bus.wr_done = 1'b1;
                    else begin
                        bus.rd_done = 1'b1;
                        bus.rd_data = bus_mem.exists(bus_a) ? bus_mem[bus_a] : init_val(bus_a);
                    end
                    busy = 1'b0;
                end else begin
                    bus_wait--;
                end
            end
            if (push_i < NRAND && $urandom_range(0, 2) != 0) begin
                bus.cmd_valid = 1'b1;
                bus.cmd_write = cmds[push_i].w;
                bus.cmd_addr  = cmds[push_i].a;
                bus.cmd_wdata = cmds[push_i].d;
                push_now = (model_cnt < DEPTH);
            end else begin
                bus.cmd_valid = 1'b0;
            end
            bus.rsp_ready = 1'($urandom_range(0, 1));
            if (bus.rsp_valid && bus.rsp_ready) begin
                rsp_i++;
                outstanding = 1'b0;
            end
            step();
            if (push_now) push_i++;
            model_cnt = model_cnt + int'(push_now) - int'(pop_now);
            cyc++;
        end
        idle_inputs();
        total++; if (rsp_i != NRAND) begin bad++; $display("FAIL rnd_complete got=%0d responses want=%0d", rsp_i, NRAND); end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_write_read();
        test_fill();
        test_backpressure();
        test_reset_mid();
        test_mismatch();
`ifdef CMDQ_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish got time=%0t want < 500000", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/axi4_lite_cmd_queue.md
Name: axi4_lite_cmd_queue

Overview:
- Request front-end sitting directly upstream of axi4_lite_master.
- Buffers read/write commands from a producer (sequencer/driver) in a FIFO.
- Issues them one at a time as single-cycle rd_en/wr_en pulses with stable address/data.
- Waits for bus completion, then returns a response (read data or write ack) to the producer.

Parameters:
- Addr_Width, 32, address width; taken from axi4_lite_Defs.
- Data_Width, 32, data width; taken from axi4_lite_Defs.
- DEPTH, 4, command FIFO entries; power of 2, minimum 2.
- TIMEOUT_CYCLES, 256, watchdog limit; used only with CMDQ_TIMEOUT_EN.

Ports:
- ACLK  in  1  clock; all logic on its rising edge.
- ARESET  in  1  synchronous, active-high reset.
- cmd_valid  in  1  producer presents a command.
- cmd_ready  out  1  queue can accept; equals !full.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  Addr_Width  command address.
- cmd_wdata  in  Data_Width  write data; ignored for reads.
- rd_en  out  1  one-cycle read-start pulse to master.
- wr_en  out  1  one-cycle write-start pulse to master.
- Read_Address  out  Addr_Width  to master.
- Write_Address  out  Addr_Width  to master.
- Write_Data  out  Data_Width  to master.
- rd_done  in  1  read completion (RVALID&&RREADY observed on bus).
- wr_done  in  1  write completion (BVALID&&BREADY observed on bus).
- rd_data  in  Data_Width  RDATA, valid when rd_done=1.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  producer accepts response.
- rsp_write  out  1  response type.
- rsp_data  out  Data_Width  read data; 0 for writes.
- rsp_err  out  1  timeout flag; tied 0 without CMDQ_TIMEOUT_EN.
- count  out  $clog2(DEPTH+1)  FIFO occupancy.

Behaviour:
- Reset (ARESET=1 at a clock edge):
  - FIFO emptied, count=0, FSM=IDLE.
  - rd_en=wr_en=rsp_valid=rsp_err=0; addresses/data/rsp_data=0; cmd_ready=1 the cycle after.
- Reset mid-transaction:
  - In-flight command and any pending response are abandoned.
  - A late rd_done/wr_done arriving in IDLE is ignored.
- Push occurs when cmd_valid && cmd_ready.
  - When full, cmd_ready=0 even if a pop happens in the same cycle; no bypass path.
  - Simultaneous push+pop when not full leaves count unchanged.
- FSM states:
  - IDLE: FIFO non-empty -> ISSUE.
  - ISSUE (exactly 1 cycle):
    - Pop the head entry.
    - Drive rd_en or wr_en =1 per cmd_write.
    - Load Read_Address or Write_Address (and Write_Data for writes).
    - -> WAIT.
  - WAIT:
    - Outputs held stable.
    - The done for the matching type -> RESP; capture rd_data into rsp_data (reads) or 0 (writes).
    - A non-matching done is ignored.
  - RESP: rsp_valid=1, held with stable payload until rsp_ready; on handshake -> IDLE.
- Latency:
  - Command pushed at edge N into an empty queue with FSM in IDLE: enable pulse asserted in cycle N+2.
  - Done seen at edge M: rsp_valid=1 from M+1.
- Ordering:
  - Strictly one outstanding transaction; responses are returned in command order.
  - The next issue starts no earlier than the cycle after the response handshake.
- Done inputs are sampled only in WAIT; done during ISSUE is ignored (master cannot complete in 0 cycles).
- FIFO pointers are log2(DEPTH) bits and wrap naturally; full/empty are derived from count.

Optional Feature:
- Macro CMDQ_TIMEOUT_EN.
- When defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - On reaching TIMEOUT_CYCLES without a matching done: -> RESP with rsp_err=1 and rsp_data=0.
  - rsp_err clears on response handshake.
- When undefined: no counter is built; WAIT waits indefinitely; rsp_err is tied 0.

Decomposition:
- Add to axi4_lite_Defs:
  - typedef struct packed {logic write; logic [Addr_Width-1:0] addr; logic [Data_Width-1:0] data;} axi4_cmd_t.
  - enum cmdq_state_t {IDLE, ISSUE, WAIT, RESP}.
- One sub-module, axi4_cmd_fifo:
  - Parameterized by DEPTH, storing axi4_cmd_t.
  - Signals: push/pop/full/empty/count.
  - Synchronous active-high reset.

Test Plan:
- Write then read, same address:
  - Stimulus: write addr=0x10 data=0xDEADBEEF; read addr=0x10.
  - Response: wr_en pulse with Write_Address=0x10; rsp_write=1 ack; then rd_en pulse; rsp_data=0xDEADBEEF.
- Fill queue:
  - Stimulus: push 5 writes back-to-back with DEPTH=4 while wr_done is withheld.
  - Response: cmd_ready=0 once count=4 (the first entry is popped at issue), resuming after the first response.
  - All 5 issue in order with no duplicates or loss.
- Response backpressure:
  - Stimulus: rsp_ready=0 for 10 cycles after a read completes with rd_data=0xA5A5A5A5.
  - Response: rsp_valid and rsp_data held stable; no new rd_en/wr_en issued.
- Reset mid-operation:
  - Stimulus: ARESET asserted in WAIT with 2 entries queued; rd_done pulsed 2 cycles after release.
  - Response: count=0, rsp_valid=0, no response generated.
- Type mismatch:
  - Stimulus: a read is in WAIT and wr_done pulses.
  - Response: state stays WAIT; completes only on rd_done.
- Timeout (with CMDQ_TIMEOUT_EN, TIMEOUT_CYCLES=16):
  - Stimulus: read issued, rd_done never asserted.
  - Response: rsp_valid=1 with rsp_err=1 and rsp_data=0, exactly 16 cycles after entering WAIT.
